uart_rx_oversample: RTL and testbench

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

---
 rtl/uart_rx_oversample.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
//
// 8N1 UART receiver that takes 16 samples per bit and decides each bit by
// a 2-of-3 majority vote over samples 7, 8 and 9. The received byte is
// presented on a valid/ready output register.
//
// Ports:
//   clk            rising-edge system clock
//   rst            synchronous active-high reset
//   uart_din       asynchronous serial line (idle high, LSB first)
//   receive_data   last delivered byte
//   receive_valid  receive_data holds an unconsumed byte
//   receive_ready  consumer accepts the byte when valid && ready
//   receive_busy   high while a frame is being received
//   receive_start  one-cycle pulse when a start bit is confirmed
//   receive_finish one-cycle pulse when the stop bit is evaluated
//   frame_error    one-cycle pulse when the stop bit samples low
//   overrun        one-cycle pulse when a good byte is dropped

`timescale 1ns/1ps

module uart_rx_oversample #(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_din,
  output logic [7:0] receive_data,
  output logic       receive_valid,
  input  logic       receive_ready,
  output logic       receive_busy,
  output logic       receive_start,
  output logic       receive_finish,
  output logic       frame_error,
  output logic       overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(BAUD_DIV - 1);

  logic          sync1;
  logic          sync2;
  logic          din_prev;
  logic [1:0]    state;
  logic [CW-1:0] tick_cnt;
  logic [3:0]    sample_idx;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          s7;
  logic          s8;
  logic          deliver;
  logic          start_edge;
  logic          tick;
  logic          majority;

  // A start edge is only meaningful while idle; inside a frame, falling
  // edges are ordinary data transitions.
  assign start_edge   = (state == IDLE) && din_prev && !sync2;
  assign tick         = (state != IDLE) && (tick_cnt == TICK_MAX);
  // Sample 9 is the live synchronized value, so the vote resolves on the
  // same tick that takes the third sample.
  assign majority     = (s7 & s8) | (s7 & sync2) | (s8 & sync2);
  assign receive_busy = (state != IDLE);

  // Two-flop synchronizer plus one extra stage holding the previous
  // synchronized sample for falling-edge detection. Resetting to 1 matches
  // an idle line so reset release does not fake an edge on a high line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      din_prev <= 1'b1;
    end else begin
      sync1    <= uart_din;
      sync2    <= sync1;
      din_prev <= sync2;
    end
  end

  // Frame FSM. The tick counter divides clk down to the 16x sample rate
  // and is restarted on the start edge so sample indices line up with the
  // bit cells. The STOP state leaves at sample 9 rather than 15 so a
  // back-to-back start edge arriving half a bit later is not missed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      sample_idx     <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      s7             <= 1'b0;
      s8             <= 1'b0;
      receive_start  <= 1'b0;
      receive_finish <= 1'b0;
      frame_error    <= 1'b0;
      deliver        <= 1'b0;
    end else begin
      receive_start  <= 1'b0;
      receive_finish <= 1'b0;
      frame_error    <= 1'b0;
      deliver        <= 1'b0;
      if (state == IDLE) begin
        if (start_edge) begin
          state      <= START;
          tick_cnt   <= '0;
          sample_idx <= '0;
        end
      end else begin
        if (tick) begin
          tick_cnt <= '0;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
        if (tick) begin
          sample_idx <= sample_idx + 4'd1;
          if (sample_idx == 4'd7) s7 <= sync2;
          if (sample_idx == 4'd8) s8 <= sync2;
          case (state)
            START: begin
              if (sample_idx == 4'd9 && majority) begin
                state <= IDLE;
              end else if (sample_idx == 4'd15) begin
                state         <= DATA;
                bit_cnt       <= '0;
                receive_start <= 1'b1;
              end
            end
            DATA: begin
              if (sample_idx == 4'd9) begin
                shift_reg <= {majority, shift_reg[7:1]};
              end
              if (sample_idx == 4'd15) begin
                if (bit_cnt == 3'd7) begin
                  state <= STOP;
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                end
              end
            end
            STOP: begin
              if (sample_idx == 4'd9) begin
                state          <= IDLE;
                receive_finish <= 1'b1;
                frame_error    <= !majority;
                deliver        <= majority;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  // Output register. A delivery coinciding with acceptance reloads the
  // register and keeps valid high; a delivery while the old byte is still
  // pending is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      receive_data  <= 8'h00;
      receive_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!receive_valid || receive_ready) begin
          receive_data  <= shift_reg;
          receive_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (receive_valid && receive_ready) begin
        receive_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample
//
// Drives serial frames into uart_rx_oversample (BAUD_DIV = 4) and checks
// delivered bytes through a scoreboard queue: expected bytes are pushed when
// a frame is issued, and an independent monitor pops them whenever the DUT
// presents a new byte. Pulse outputs are counted by the monitor and compared
// per scenario against counts derived from the frames sent.

`timescale 1ns/1ps

module tb_uart_rx_oversample;

  localparam int B   = 4;
  localparam int BIT = 16 * B;

  logic       clk;
  logic       rst;
  logic       uart_din;
  logic [7:0] receive_data;
  logic       receive_valid;
  logic       receive_ready;
  logic       receive_busy;
  logic       receive_start;
  logic       receive_finish;
  logic       frame_error;
  logic       overrun;

  uart_rx_oversample #(.BAUD_DIV(B)) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_din       (uart_din),
    .receive_data   (receive_data),
    .receive_valid  (receive_valid),
    .receive_ready  (receive_ready),
    .receive_busy   (receive_busy),
    .receive_start  (receive_start),
    .receive_finish (receive_finish),
    .frame_error    (frame_error),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests;
  int         fails;
  logic [7:0] exp_q[$];

  int start_seen, finish_seen, ferr_seen, ovr_seen, valid_cycles, busy_cycles;
  int snap_start, snap_finish, snap_ferr, snap_ovr, snap_valid, snap_busy;

  time        fall_time;
  time        last_rise_time;
  logic       rand_ready;
  logic       prev_valid;
  logic [7:0] prev_data;
  logic       accepted;
  logic [7:0] expected_byte;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  task automatic take_snapshot();
    snap_start  = start_seen;
    snap_finish = finish_seen;
    snap_ferr   = ferr_seen;
    snap_ovr    = ovr_seen;
    snap_valid  = valid_cycles;
    snap_busy   = busy_cycles;
  endtask

  task automatic check_counts(input string tag, input int e_start, input int e_finish,
                              input int e_ferr, input int e_ovr);
    check_output({tag, "_start"},  start_seen  - snap_start,  e_start);
    check_output({tag, "_finish"}, finish_seen - snap_finish, e_finish);
    check_output({tag, "_ferr"},   ferr_seen   - snap_ferr,   e_ferr);
    check_output({tag, "_ovr"},    ovr_seen    - snap_ovr,    e_ovr);
  endtask

  // One 8N1 frame, each bit held for 16 sample ticks. With glitch set, the
  // line is inverted for one tick positioned so only sample 8 sees it.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit,
                                input logic glitch);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0) fall_time = $time;
        uart_din = frame[b] ^ (glitch && c >= 8 * B + 1 && c <= 9 * B);
      end
    end
  endtask

  task automatic idle_line(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      uart_din = 1'b1;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check_output("queue_drained", exp_q.size(), 0);
  endtask

  // Random consumer back-pressure, active only in the randomized phase.
  always @(negedge clk) begin
    if (rand_ready) receive_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: samples 1ns after each rising edge. receive_ready at that
  // point is the value the DUT used on this edge, so a handshake on this
  // edge is prev_valid && receive_ready.
  always @(posedge clk) begin
    #1;
    accepted = prev_valid && receive_ready;
    if (receive_valid)  valid_cycles++;
    if (receive_busy)   busy_cycles++;
    if (receive_start)  start_seen++;
    if (receive_finish) finish_seen++;
    if (frame_error)    ferr_seen++;
    if (overrun)        ovr_seen++;
    if (frame_error) check_output("ferr_with_finish", receive_finish, 1);
    if (!rst && prev_valid && !accepted) begin
      check_output("hold_valid", receive_valid, 1);
      check_output("hold_data", receive_data, prev_data);
    end else if (receive_valid && (!prev_valid || accepted)) begin
      last_rise_time = $time - 1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_byte: got 'h%0h, expected no byte", receive_data);
      end else begin
        expected_byte = exp_q.pop_front();
        check_output("byte", receive_data, expected_byte);
      end
    end
    prev_valid = receive_valid;
    prev_data  = receive_data;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    int   busy;
    int   nbad;
    logic [7:0] d;
    logic good;

    tests = 0; fails = 0;
    start_seen = 0; finish_seen = 0; ferr_seen = 0; ovr_seen = 0;
    valid_cycles = 0; busy_cycles = 0;
    prev_valid = 1'b0; prev_data = 8'h00;
    rand_ready = 1'b0;
    rst = 1'b1; uart_din = 1'b1; receive_ready = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    check_output("rst_data",   receive_data,   8'h00);
    check_output("rst_valid",  receive_valid,  0);
    check_output("rst_busy",   receive_busy,   0);
    check_output("rst_start",  receive_start,  0);
    check_output("rst_finish", receive_finish, 0);
    check_output("rst_ferr",   frame_error,    0);
    check_output("rst_ovr",    overrun,        0);
    rst = 1'b0;
    idle_line(2 * BIT);

    // Clean frame, consumer always ready; also measures latency
    receive_ready = 1'b1;
    take_snapshot();
    exp_q.push_back(8'hA5);
    apply_stimulus(8'hA5, 1'b1, 1'b0);
    idle_line(BIT);
    wait_drain(4 * BIT);
    check_counts("a5", 1, 1, 0, 0);
    check_output("a5_valid_cycles", valid_cycles - snap_valid, 1);
    lat = int'((last_rise_time - (fall_time + 5)) / 10) + 1;
    tests++;
    if (lat < 154 * B + 3 || lat > 154 * B + 5) begin
      fails++;
      $display("[TB] FAIL latency: got %0d clk, expected %0d..%0d clk",
               lat, 154 * B + 3, 154 * B + 5);
    end

    // Short low glitch on an idle line
    take_snapshot();
    @(negedge clk);
    uart_din = 1'b0;
    repeat (4) @(negedge clk);
    uart_din = 1'b1;
    idle_line(20 * B + 10);
    check_counts("glitch", 0, 0, 0, 0);
    check_output("glitch_valid_cycles", valid_cycles - snap_valid, 0);
    busy = busy_cycles - snap_busy;
    tests++;
    if (busy < 1 || busy > 10 * B + 4) begin
      fails++;
      $display("[TB] FAIL glitch_busy: got %0d clk, expected 1..%0d clk", busy, 10 * B + 4);
    end

    // Bad stop bit
    take_snapshot();
    apply_stimulus(8'h3C, 1'b0, 1'b0);
    idle_line(BIT);
    check_counts("ferr", 1, 1, 1, 0);
    check_output("ferr_valid_cycles", valid_cycles - snap_valid, 0);

    // Back-to-back frames with a stalled consumer
    receive_ready = 1'b0;
    take_snapshot();
    exp_q.push_back(8'h11);
    apply_stimulus(8'h11, 1'b1, 1'b0);
    apply_stimulus(8'h22, 1'b1, 1'b0);
    idle_line(BIT);
    check_counts("b2b", 2, 2, 0, 1);
    check_output("b2b_data",  receive_data,  8'h11);
    check_output("b2b_valid", receive_valid, 1);
    check_output("b2b_queue", exp_q.size(),  0);
    receive_ready = 1'b1;
    @(negedge clk);
    check_output("b2b_cleared", receive_valid, 0);
    idle_line(BIT);

    // Reset in the middle of a frame, then a fresh frame
    take_snapshot();
    fork
      apply_stimulus(8'h55, 1'b1, 1'b0);
      begin
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        rst = 1'b1;
      end
    join
    repeat (BIT) @(negedge clk);
    check_output("midrst_busy",  receive_busy,  0);
    check_output("midrst_valid", receive_valid, 0);
    rst = 1'b0;
    idle_line(2 * BIT);
    check_counts("midrst", 1, 0, 0, 0);
    check_output("midrst_valid_cycles", valid_cycles - snap_valid, 0);
    take_snapshot();
    exp_q.push_back(8'h0F);
    apply_stimulus(8'h0F, 1'b1, 1'b0);
    idle_line(BIT);
    wait_drain(4 * BIT);
    check_counts("after_rst", 1, 1, 0, 0);

    // Mid-bit glitch on every bit, outvoted by the other two samples
    take_snapshot();
    exp_q.push_back(8'hF0);
    apply_stimulus(8'hF0, 1'b1, 1'b1);
    idle_line(BIT);
    wait_drain(4 * BIT);
    check_counts("vote", 1, 1, 0, 0);

    // Break: line held low far longer than a frame
    take_snapshot();
    @(negedge clk);
    uart_din = 1'b0;
    repeat (16 * BIT) @(negedge clk);
    idle_line(4 * BIT);
    check_counts("break", 1, 1, 1, 0);
    check_output("break_valid_cycles", valid_cycles - snap_valid, 0);

    // Randomized frames, gaps and consumer back-pressure
    take_snapshot();
    rand_ready = 1'b1;
    nbad = 0;
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      if (good) exp_q.push_back(d);
      else      nbad++;
      apply_stimulus(d, good, 1'b0);
      if (!good) idle_line(BIT + int'($urandom_range(0, BIT)));
      else       idle_line(int'($urandom_range(0, 2 * BIT)));
    end
    idle_line(BIT);
    wait_drain(8 * BIT);
    @(negedge clk);
    rand_ready = 1'b0;
    receive_ready = 1'b1;
    idle_line(8);
    check_counts("rand", 12, 12, nbad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
